// File: rtl/jtag_tap_gen.sv
// Parametrised 1149.1 TAP controller: ID, BYPASS and NREG user data registers with capture/update strobes.
// Define JTAG_PARITY_EN to append an even-parity bit to every user register scan.
module jtag_tap_gen #(
    parameter int                   IR_W    = 5,
    parameter int                   DR_W    = 69,
    parameter int                   NREG    = 8,
    parameter int                   ID_W    = 40,
    parameter logic [NREG*8-1:0]    LEN_VEC = {NREG{8'd69}},
    parameter logic [NREG*DR_W-1:0] RST_VEC = '0
) (
    input  logic                   tck,
    input  logic                   hard_rst,
    input  logic                   tms,
    input  logic                   tdi,
    output logic                   tdo,
    output logic [3:0]             jstate,
    output logic [IR_W-1:0]        ir,
    input  logic [ID_W-1:0]        id,
    input  logic [NREG*DR_W-1:0]   rd_data,
    output logic [NREG*DR_W-1:0]   wr_data,
    output logic [NREG-1:0]        cap_strb,
    output logic [NREG-1:0]        wr_strb,
    output logic                   par_err
);
`ifdef JTAG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SH_W = (ID_W > DR_W + PAR) ? ID_W : DR_W + PAR;

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_t;

    tap_t                 r_state;
    logic [IR_W-1:0]      r_ir;
    logic [IR_W-1:0]      r_ish;
    logic [SH_W-1:0]      r_dsh;
    logic [NREG*DR_W-1:0] r_wr_data;
    logic [NREG-1:0]      r_cap_strb;
    logic [NREG-1:0]      r_wr_strb;
    logic                 r_tdo;
    logic                 r_par_err;

    logic [NREG-1:0]      w_sel_oh;
    logic                 w_user;
    logic                 w_is_id;
    logic [7:0]           w_len;
    logic [DR_W-1:0]      w_cdata;
    logic [DR_W-1:0]      w_udata;
    logic [SH_W-1:0]      w_cap;
    logic [SH_W-1:0]      w_topbit;
    logic [SH_W-1:0]      w_dshift;
    logic [IR_W-1:0]      w_ir_cap;
    logic                 w_par_bad;

    function automatic logic [DR_W-1:0] f_lenmask(input logic [7:0] len);
        logic [DR_W:0] m;
        m = ((DR_W+1)'(1) << len) - (DR_W+1)'(1);
        return m[DR_W-1:0];
    endfunction

    // Opcode k+1 selects user register k; everything else that is not 0 is bypass.
    always_comb begin
        w_sel_oh = '0;
        w_len    = 8'd1;
        w_cdata  = '0;
        for (int i = 0; i < NREG; i++) begin
            if (r_ir == IR_W'(i + 1)) begin
                w_sel_oh[i] = 1'b1;
                w_len       = LEN_VEC[i*8 +: 8];
                w_cdata     = rd_data[i*DR_W +: DR_W] & f_lenmask(LEN_VEC[i*8 +: 8]);
            end
        end
    end

    assign w_user   = |w_sel_oh;
    assign w_is_id  = (r_ir == '0);
    assign w_udata  = r_dsh[DR_W-1:0] & f_lenmask(w_len);
    assign w_ir_cap = IR_W'({r_par_err, 2'b01});

    // One shared DR shifter; w_topbit marks where tdi enters for the active register.
    always_comb begin
        w_cap    = '0;
        w_topbit = SH_W'(1);
        if (w_is_id) begin
            w_cap    = SH_W'(id);
            w_topbit = SH_W'(1) << (ID_W - 1);
        end else if (w_user) begin
            w_cap    = SH_W'(w_cdata);
`ifdef JTAG_PARITY_EN
            w_cap    = w_cap | (SH_W'(^w_cdata) << w_len);
`endif
            w_topbit = SH_W'(1) << (32'(w_len) + PAR - 1);
        end
        w_dshift = ({1'b0, r_dsh[SH_W-1:1]} & (w_topbit - SH_W'(1))) | (tdi ? w_topbit : '0);
    end

`ifdef JTAG_PARITY_EN
    logic [SH_W-1:0] w_pshift;
    assign w_pshift  = r_dsh >> w_len;
    assign w_par_bad = w_pshift[0] ^ (^w_udata);
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge tck or posedge hard_rst) begin
        if (hard_rst) begin
            r_state    <= TLR;
            r_ir       <= '0;
            r_ish      <= '0;
            r_dsh      <= '0;
            r_wr_data  <= RST_VEC;
            r_cap_strb <= '0;
            r_wr_strb  <= '0;
            r_par_err  <= 1'b0;
        end else begin
            r_cap_strb <= '0;
            r_wr_strb  <= '0;
            case (r_state)
                TLR: begin
                    r_state <= tms ? TLR : RTI;
                    r_ir    <= '0;
                end
                RTI:    r_state <= tms ? SEL_DR : RTI;
                SEL_DR: begin
                    r_state <= tms ? SEL_IR : CAP_DR;
                    if (!tms) r_cap_strb <= w_sel_oh;
                end
                CAP_DR: begin
                    r_state <= tms ? EX1_DR : SH_DR;
                    r_dsh   <= w_cap;
                end
                SH_DR: begin
                    r_state <= tms ? EX1_DR : SH_DR;
                    r_dsh   <= w_dshift;
                end
                EX1_DR, EX2_DR: begin
                    if (tms) begin
                        r_state <= UPD_DR;
                        if (w_user && w_par_bad) begin
                            r_par_err <= 1'b1;
                        end else if (w_user) begin
                            r_wr_strb <= w_sel_oh;
                            for (int i = 0; i < NREG; i++)
                                if (w_sel_oh[i]) r_wr_data[i*DR_W +: DR_W] <= w_udata;
                        end
                    end else begin
                        r_state <= (r_state == EX1_DR) ? PAU_DR : SH_DR;
                    end
                end
                PAU_DR:         r_state <= tms ? EX2_DR : PAU_DR;
                UPD_DR, UPD_IR: r_state <= tms ? SEL_DR : RTI;
                SEL_IR: begin
                    r_state <= tms ? TLR : CAP_IR;
                    if (tms) r_ir <= '0;
                end
                CAP_IR: begin
                    r_state <= tms ? EX1_IR : SH_IR;
                    r_ish   <= w_ir_cap;
                end
                SH_IR: begin
                    r_state <= tms ? EX1_IR : SH_IR;
                    r_ish   <= {tdi, r_ish[IR_W-1:1]};
                end
                EX1_IR, EX2_IR: begin
                    if (tms) begin
                        r_state <= UPD_IR;
                        r_ir    <= r_ish;
                        if (&r_ish) r_par_err <= 1'b0;
                    end else begin
                        r_state <= (r_state == EX1_IR) ? PAU_IR : SH_IR;
                    end
                end
                PAU_IR:  r_state <= tms ? EX2_IR : PAU_IR;
                default: r_state <= TLR;
            endcase
        end
    end

    always_ff @(negedge tck or posedge hard_rst) begin
        if (hard_rst)              r_tdo <= 1'b0;
        else if (r_state == SH_DR) r_tdo <= r_dsh[0];
        else if (r_state == SH_IR) r_tdo <= r_ish[0];
        else                       r_tdo <= 1'b0;
    end

    assign tdo      = r_tdo;
    assign jstate   = ~r_state;
    assign ir       = r_ir;
    assign wr_data  = r_wr_data;
    assign cap_strb = r_cap_strb;
    assign wr_strb  = r_wr_strb;
    assign par_err  = r_par_err;
endmodule

// File: tb/tb_jtag_tap_gen.sv
// Directed/randomized bench for jtag_tap_gen with a register-level scoreboard.
module tb_jtag_tap_gen;
    localparam int IR_W = 5;
    localparam int DR_W = 69;
    localparam int NREG = 8;
    localparam int ID_W = 40;
`ifdef JTAG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LENS [NREG] = '{8, 20, 12, 69, 69, 1, 33, 69};
    localparam logic [NREG*8-1:0] LEN_VEC = {8'd69, 8'd33, 8'd1, 8'd69, 8'd69, 8'd12, 8'd20, 8'd8};
    localparam logic [NREG*DR_W-1:0] RST_VEC =
        ((NREG*DR_W)'(8'h5A)) | ((NREG*DR_W)'(12'h3C5) << (2*DR_W));

    logic                 tck = 1'b0;
    logic                 hard_rst;
    logic                 tms;
    logic                 tdi;
    logic                 tdo;
    logic [3:0]           jstate;
    logic [IR_W-1:0]      ir;
    logic [ID_W-1:0]      id;
    logic [NREG*DR_W-1:0] rd_data;
    logic [NREG*DR_W-1:0] wr_data;
    logic [NREG-1:0]      cap_strb;
    logic [NREG-1:0]      wr_strb;
    logic                 par_err;

    int vectors = 0;
    int miscompares = 0;
    logic [DR_W-1:0] m_wr [NREG];
    logic            m_par;

    jtag_tap_gen #(.IR_W(IR_W), .DR_W(DR_W), .NREG(NREG), .ID_W(ID_W),
                   .LEN_VEC(LEN_VEC), .RST_VEC(RST_VEC)) dut (
        .tck(tck), .hard_rst(hard_rst), .tms(tms), .tdi(tdi), .tdo(tdo),
        .jstate(jstate), .ir(ir), .id(id), .rd_data(rd_data), .wr_data(wr_data),
        .cap_strb(cap_strb), .wr_strb(wr_strb), .par_err(par_err)
    );

    always #5 tck = ~tck;

    function automatic logic [DR_W:0] lmask(input int len);
        return ((DR_W+1)'(1) << len) - (DR_W+1)'(1);
    endfunction

    function automatic logic [DR_W-1:0] rd_slice(input int k);
        return rd_data[k*DR_W +: DR_W];
    endfunction

    function automatic logic [DR_W-1:0] wr_slice(input int k);
        return wr_data[k*DR_W +: DR_W];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_wr(input string tag);
        for (int k = 0; k < NREG; k++)
            chk($sformatf("%s_wr%0d", tag, k), 128'(wr_slice(k)), 128'(m_wr[k]));
    endtask

    // o is tdo as seen during the cycle whose rising edge consumes t/d.
    task automatic clk1(input logic t, input logic d, output logic o);
        @(negedge tck);
        #1;
        o   = tdo;
        tms = t;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic scan_ir(input logic [IR_W-1:0] v, output logic [IR_W-1:0] cap);
        logic o;
        cap = '0;
        clk1(1'b1, 1'b0, o);
        clk1(1'b1, 1'b0, o);
        clk1(1'b0, 1'b0, o);
        clk1(1'b0, 1'b0, o);
        for (int i = 0; i < IR_W; i++) begin
            clk1(i == IR_W - 1, v[i], o);
            cap[i] = o;
        end
        clk1(1'b1, 1'b0, o);
        if (&v) m_par = 1'b0;
        chk($sformatf("ir_load_%0h", v), 128'(ir), 128'(v));
        chk("ir_par_err", 128'(par_err), 128'(m_par));
        clk1(1'b0, 1'b0, o);
    endtask

    task automatic scan_dr(input int n, input logic [127:0] din, output logic [127:0] dout,
                           input logic [NREG-1:0] exp_cap, input logic [NREG-1:0] exp_wr,
                           input string tag);
        logic o;
        dout = '0;
        clk1(1'b1, 1'b0, o);
        clk1(1'b0, 1'b0, o);
        chk({tag, "_cap_strb"}, 128'(cap_strb), 128'(exp_cap));
        clk1(1'b0, 1'b0, o);
        chk({tag, "_cap_strb_off"}, 128'(cap_strb), 128'(0));
        for (int i = 0; i < n; i++) begin
            clk1(i == n - 1, din[i], o);
            dout[i] = o;
        end
        clk1(1'b1, 1'b0, o);
        chk({tag, "_wr_strb"}, 128'(wr_strb), 128'(exp_wr));
        clk1(1'b0, 1'b0, o);
        chk({tag, "_wr_strb_off"}, 128'(wr_strb), 128'(0));
    endtask

    task automatic wr_user(input int k, input logic [DR_W-1:0] data, input string tag);
        logic [127:0]    din;
        logic [127:0]    dout;
        logic [127:0]    expo;
        logic [DR_W-1:0] d;
        logic [DR_W-1:0] c;
        d    = data & DR_W'(lmask(LENS[k]));
        c    = rd_slice(k) & DR_W'(lmask(LENS[k]));
        din  = 128'(d);
        expo = 128'(c);
        if (PAR != 0) begin
            din[LENS[k]]  = ^d;
            expo[LENS[k]] = ^c;
        end
        scan_dr(LENS[k] + PAR, din, dout, NREG'(1) << k, NREG'(1) << k, tag);
        chk({tag, "_readback"}, dout, expo);
        m_wr[k] = d;
        chk({tag, "_wr_data"}, 128'(wr_slice(k)), 128'(m_wr[k]));
    endtask

    task automatic bypass_scan(input int n, input string tag);
        logic [127:0] din;
        logic [127:0] dout;
        din = {$urandom, $urandom, $urandom, $urandom};
        scan_dr(n, din, dout, '0, '0, tag);
        chk({tag, "_delay1"}, dout, (din << 1) & ((128'(1) << n) - 128'(1)));
    endtask

    initial begin
        #800000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [IR_W-1:0] c;
        logic [127:0]    dout;
        logic [DR_W:0]   win;
        logic [DR_W-1:0] d;
        logic            o;
        logic            b;
        logic            ok;
        int              k;
        int              w;

        hard_rst = 1'b1;
        tms      = 1'b0;
        tdi      = 1'b0;
        id       = 40'hA5_1234_5678;
        m_par    = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            rd_data[i*DR_W +: DR_W] = DR_W'({$urandom, $urandom, $urandom});
            m_wr[i] = RST_VEC[i*DR_W +: DR_W];
        end

        // Reset state
        repeat (2) @(posedge tck);
        #1;
        chk("rst_jstate", 128'(jstate), 128'(4'hF));
        chk("rst_ir", 128'(ir), 128'(0));
        chk("rst_tdo", 128'(tdo), 128'(0));
        chk("rst_cap_strb", 128'(cap_strb), 128'(0));
        chk("rst_wr_strb", 128'(wr_strb), 128'(0));
        chk("rst_par_err", 128'(par_err), 128'(0));
        chk_all_wr("rst");
        hard_rst = 1'b0;
        clk1(1'b0, 1'b0, o);
        chk("rti_jstate", 128'(jstate), 128'(4'hE));

        // IDRead
        scan_dr(ID_W, {$urandom, $urandom}, dout, '0, '0, "id");
        chk("id_readback", dout, 128'(id));
        chk_all_wr("id");

        // Register 2 (12 bits)
        scan_ir(5'd3, c);
        chk("ircap_reg2", 128'(c), 128'({m_par, 2'b01}));
        wr_user(2, 69'hABC, "reg2");

        // Boundary lengths, then random registers and data
        scan_ir(5'd6, c);
        wr_user(5, DR_W'({$urandom, $urandom, $urandom}), "reg5_len1");
        scan_ir(5'd8, c);
        wr_user(7, DR_W'({$urandom, $urandom, $urandom}), "reg7_len69");
        for (int t = 0; t < 8; t++) begin
            k = $urandom_range(NREG - 1);
            rd_data[k*DR_W +: DR_W] = DR_W'({$urandom, $urandom, $urandom});
            scan_ir(IR_W'(k + 1), c);
            wr_user(k, DR_W'({$urandom, $urandom, $urandom}), $sformatf("rnd%0d_reg%0d", t, k));
        end
        chk_all_wr("after_rnd");

        // Bypass: all-ones and an unused code
        scan_ir(5'h1F, c);
        chk("ircap_bypass_low", 128'(c[1:0]), 128'(2'b01));
        scan_dr(5, 128'h0D, dout, '0, '0, "byp1011");
        chk("byp1011_out", dout, 128'h1A);
        bypass_scan(24, "byp_rnd");
        scan_ir(5'd9, c);
        bypass_scan(17, "unused9");
        chk_all_wr("bypass");

        // Five tms=1 clocks from mid-ShiftDR on register 0
        scan_ir(5'd1, c);
        w   = LENS[0] + PAR;
        d   = rd_slice(0) & DR_W'(lmask(LENS[0]));
        win = (DR_W+1)'(d);
        if (PAR != 0) win[LENS[0]] = ^d;
        clk1(1'b1, 1'b0, o);
        clk1(1'b0, 1'b0, o);
        chk("abort_cap_strb", 128'(cap_strb), 128'(1));
        clk1(1'b0, 1'b0, o);
        for (int i = 0; i < 8; i++) begin
            b = 1'($urandom);
            clk1(i >= 3, b, o);
            if (i <= 3) win = (win >> 1) | ((DR_W+1)'(b) << (w - 1));
            if (i == 4) begin
                d  = DR_W'(win) & DR_W'(lmask(LENS[0]));
                ok = (PAR == 0) || (win[LENS[0]] == ^d);
                chk("abort_upd_strb", 128'(wr_strb), ok ? 128'(1) : 128'(0));
                if (ok) m_wr[0] = d;
                else    m_par   = 1'b1;
            end
        end
        chk("abort_jstate", 128'(jstate), 128'(4'hF));
        chk("abort_ir", 128'(ir), 128'(0));
        chk("abort_par_err", 128'(par_err), 128'(m_par));
        chk_all_wr("abort");
        clk1(1'b0, 1'b0, o);

        // hard_rst in the middle of a register 1 scan
        scan_ir(5'd2, c);
        clk1(1'b1, 1'b0, o);
        clk1(1'b0, 1'b0, o);
        clk1(1'b0, 1'b0, o);
        for (int i = 0; i < 4; i++) clk1(1'b0, 1'($urandom), o);
        hard_rst = 1'b1;
        #2;
        for (int i = 0; i < NREG; i++) m_wr[i] = RST_VEC[i*DR_W +: DR_W];
        m_par = 1'b0;
        chk("hrst_jstate", 128'(jstate), 128'(4'hF));
        chk("hrst_ir", 128'(ir), 128'(0));
        chk("hrst_tdo", 128'(tdo), 128'(0));
        @(posedge tck);
        #1;
        chk("hrst_wr_strb", 128'(wr_strb), 128'(0));
        chk_all_wr("hrst");
        hard_rst = 1'b0;
        clk1(1'b0, 1'b0, o);
        chk("hrst_rti", 128'(jstate), 128'(4'hE));
        scan_dr(ID_W, 128'h0, dout, '0, '0, "id2");
        chk("id2_readback", dout, 128'(id));

`ifdef JTAG_PARITY_EN
        // Wrong parity on register 2: data 0x001 needs parity 1, send 0
        scan_ir(5'd3, c);
        scan_dr(LENS[2] + 1, 128'h001, dout, 8'h04, 8'h00, "par_bad");
        m_par = 1'b1;
        chk("par_bad_flag", 128'(par_err), 128'(1));
        chk_all_wr("par_bad");
        scan_ir(5'd3, c);
        chk("par_ircap", 128'(c), 128'(5'b00101));
        scan_ir(5'h1F, c);
        chk("par_cleared", 128'(par_err), 128'(0));
`endif

        chk("final_par_err", 128'(par_err), 128'(m_par));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
